gerador_de_periodo: RTL and testbench

GERADOR_DE_PERIODO -- requirements
Module: gerador_de_periodo

---
 rtl/gerador_de_periodo_pkg.sv | 13 +
 rtl/gerador_de_periodo_if.sv | 40 ++++
 rtl/gerador_config.sv | 105 ++++++++++
 rtl/gerador_de_periodo.sv | 119 +++++++++++
 tb/tb_gerador_de_periodo.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/gerador_de_periodo_pkg.sv
// gerador_de_periodo_pkg: state encoding and default width shared by
// the period generator and the period-measurement block.
package gerador_de_periodo_pkg;

  localparam int LARGURA_PADRAO = 12;

  typedef enum logic [1:0] {
    PARADO = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2
  } estado_t;

endpackage

// File: rtl/gerador_de_periodo_if.sv
// gerador_de_periodo_if: config/control inputs and waveform/status
// outputs of the period generator. master drives, slave generates.
interface gerador_de_periodo_if
  import gerador_de_periodo_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) ();

  logic [LARGURA-1:0] periodo;
  logic [LARGURA-1:0] largura;
  logic               carregar;
  logic               habilita;
  logic               sinal;
  logic               ocupado;
  logic [LARGURA-1:0] ciclos_gerados;
  logic               erro_config;

  modport master (
    output periodo,
    output largura,
    output carregar,
    output habilita,
    input  sinal,
    input  ocupado,
    input  ciclos_gerados,
    input  erro_config
  );

  modport slave (
    input  periodo,
    input  largura,
    input  carregar,
    input  habilita,
    output sinal,
    output ocupado,
    output ciclos_gerados,
    output erro_config
  );

endinterface

// File: rtl/gerador_config.sv
// gerador_config: validates loads, holds pending and active config.
// Ports: clock/reset; periodo_i/largura_i/carregar_i load request;
// parado_i (FSM idle), fronteira_i (BAIXO->ALTO edge); active
// periodo_o/largura_o/valido_o and sticky erro_o.
module gerador_config
  import gerador_de_periodo_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] periodo_i,
  input  logic [LARGURA-1:0] largura_i,
  input  logic               carregar_i,
  input  logic               parado_i,
  input  logic               fronteira_i,
  output logic [LARGURA-1:0] periodo_o,
  output logic [LARGURA-1:0] largura_o,
  output logic               valido_o,
  output logic               erro_o
);

  logic [LARGURA-1:0] pend_per_q, pend_per_d;
  logic [LARGURA-1:0] pend_lar_q, pend_lar_d;
  logic               pend_val_q, pend_val_d;
  logic [LARGURA-1:0] at_per_q, at_per_d;
  logic [LARGURA-1:0] at_lar_q, at_lar_d;
  logic               at_val_q, at_val_d;
  logic               erro_q, erro_d;
  logic               valida;
  logic               aceita;

  // largura < periodo already implies largura <= periodo-1
  assign valida = (periodo_i >= LARGURA'(2))
               && (largura_i != '0)
               && (largura_i < periodo_i);
  assign aceita = carregar_i && valida;

  always_comb begin
    pend_per_d = pend_per_q;
    pend_lar_d = pend_lar_q;
    pend_val_d = pend_val_q;
    at_per_d   = at_per_q;
    at_lar_d   = at_lar_q;
    at_val_d   = at_val_q;
    erro_d     = erro_q;
    if (carregar_i) begin
      erro_d = !valida;
    end
    if (parado_i) begin
      // idle: a new load (or a leftover pending one) goes live now
      if (aceita) begin
        at_per_d   = periodo_i;
        at_lar_d   = largura_i;
        at_val_d   = 1'b1;
        pend_val_d = 1'b0;
      end else if (pend_val_q) begin
        at_per_d   = pend_per_q;
        at_lar_d   = pend_lar_q;
        at_val_d   = 1'b1;
        pend_val_d = 1'b0;
      end
    end else begin
      // running: promote first, so a load on the boundary
      // edge waits for the next one
      if (fronteira_i && pend_val_q) begin
        at_per_d   = pend_per_q;
        at_lar_d   = pend_lar_q;
        at_val_d   = 1'b1;
        pend_val_d = 1'b0;
      end
      if (aceita) begin
        pend_per_d = periodo_i;
        pend_lar_d = largura_i;
        pend_val_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_per_q <= '0;
      pend_lar_q <= '0;
      pend_val_q <= 1'b0;
      at_per_q   <= '0;
      at_lar_q   <= '0;
      at_val_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      pend_per_q <= pend_per_d;
      pend_lar_q <= pend_lar_d;
      pend_val_q <= pend_val_d;
      at_per_q   <= at_per_d;
      at_lar_q   <= at_lar_d;
      at_val_q   <= at_val_d;
      erro_q     <= erro_d;
    end
  end

  assign periodo_o = at_per_q;
  assign largura_o = at_lar_q;
  assign valido_o  = at_val_q;
  assign erro_o    = erro_q;

endmodule

// File: rtl/gerador_de_periodo.sv
// gerador_de_periodo: programmable square-wave generator.
// Ports: clock, reset (async, active high); bus (slave): periodo,
// largura, carregar, habilita in; sinal, ocupado, ciclos_gerados,
// erro_config out.
module gerador_de_periodo
  import gerador_de_periodo_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic           clock,
  input  logic           reset,
  gerador_de_periodo_if.slave bus
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] cont_q, cont_d;
  logic [LARGURA-1:0] ciclos_q, ciclos_d;
  logic               sinal_q, sinal_d;
  logic               ocupado_q, ocupado_d;

  logic [LARGURA-1:0] cfg_per;
  logic [LARGURA-1:0] cfg_lar;
  logic               cfg_val;
  logic               cfg_erro;
  logic               fim_alto;
  logic               fim_periodo;
  logic               fronteira;

  // cont_q counts cycles elapsed within the current period
  assign fim_alto    = (cont_q == cfg_lar - LARGURA'(1));
  assign fim_periodo = (cont_q == cfg_per - LARGURA'(1));
  assign fronteira   = (estado_q == BAIXO) && fim_periodo
                    && bus.habilita;

  gerador_config #(
    .LARGURA (LARGURA)
  ) u_config (
    .clock       (clock),
    .reset       (reset),
    .periodo_i   (bus.periodo),
    .largura_i   (bus.largura),
    .carregar_i  (bus.carregar),
    .parado_i    (estado_q == PARADO),
    .fronteira_i (fronteira),
    .periodo_o   (cfg_per),
    .largura_o   (cfg_lar),
    .valido_o    (cfg_val),
    .erro_o      (cfg_erro)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= PARADO;
      cont_q    <= '0;
      ciclos_q  <= '0;
      sinal_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      ciclos_q  <= ciclos_d;
      sinal_q   <= sinal_d;
      ocupado_q <= ocupado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    ciclos_d = ciclos_q;
    unique case (estado_q)
      PARADO: begin
        cont_d = '0;
        if (bus.habilita && cfg_val) begin
          estado_d = ALTO;
        end
      end
      ALTO: begin
        if (!bus.habilita) begin
          estado_d = PARADO;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + LARGURA'(1);
          if (fim_alto) begin
            estado_d = BAIXO;
          end
        end
      end
      BAIXO: begin
        if (fim_periodo) begin
          // full period done, whether continuing or stopping
          ciclos_d = ciclos_q + LARGURA'(1);
          cont_d   = '0;
          estado_d = bus.habilita ? ALTO : PARADO;
        end else if (!bus.habilita) begin
          estado_d = PARADO;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + LARGURA'(1);
        end
      end
      default: begin
        estado_d = PARADO;
        cont_d   = '0;
      end
    endcase
  end

  always_comb begin
    sinal_d   = (estado_d == ALTO);
    ocupado_d = (estado_d != PARADO);
  end

  assign bus.sinal          = sinal_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.ciclos_gerados = ciclos_q;
  assign bus.erro_config    = cfg_erro;

endmodule

// File: tb/tb_gerador_de_periodo.sv
// tb_gerador_de_periodo: scoreboard bench for gerador_de_periodo.
// Expected waveform queued per period, popped each clock.
module tb_gerador_de_periodo;
  import gerador_de_periodo_pkg::*;

  localparam int W = LARGURA_PADRAO;

  logic clock = 1'b0;
  logic reset;

  gerador_de_periodo_if #(.LARGURA(W)) bus ();

  gerador_de_periodo #(
    .LARGURA (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int testes = 0;
  int falhas = 0;
  bit exp_q[$];

  task automatic verifica(input string tag, input int obs,
                          input int esp);
    testes++;
    if (obs != esp) begin
      falhas++;
      $display("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic empilha(input int p, input int l);
    for (int i = 0; i < p; i++) exp_q.push_back(i < l);
  endtask

  task automatic roda(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        verifica("sb_vazio", 0, 1);
      end else begin
        verifica("sinal", int'(bus.sinal), int'(exp_q.pop_front()));
        verifica("ocupado", int'(bus.ocupado), 1);
      end
    end
  endtask

  task automatic carrega(input int p, input int l, input bit sb);
    bus.periodo  = W'(p);
    bus.largura  = W'(l);
    bus.carregar = 1'b1;
    if (sb) roda(1);
    else tick();
    bus.carregar = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: obtido timeout esperado fim");
    $fatal(1, "watchdog");
  end

  initial begin
    int subidas;
    int ultimo;
    int gap;
    logic ant;

    bus.periodo  = '0;
    bus.largura  = '0;
    bus.carregar = 1'b0;
    bus.habilita = 1'b0;
    reset        = 1'b1;
    repeat (3) tick();
    verifica("rst_sinal", int'(bus.sinal), 0);
    verifica("rst_ocupado", int'(bus.ocupado), 0);
    verifica("rst_ciclos", int'(bus.ciclos_gerados), 0);
    verifica("rst_erro", int'(bus.erro_config), 0);
    reset = 1'b0;

    // habilita with no config is ignored
    bus.habilita = 1'b1;
    repeat (4) tick();
    verifica("hab_sem_cfg", int'(bus.ocupado), 0);
    verifica("hab_sem_cfg_s", int'(bus.sinal), 0);
    bus.habilita = 1'b0;

    // 10/4 basic
    carrega(10, 4, 0);
    bus.habilita = 1'b1;
    empilha(10, 4);
    empilha(10, 4);
    roda(10);
    verifica("ciclos_10c", int'(bus.ciclos_gerados), 0);
    roda(1);
    verifica("ciclos_1", int'(bus.ciclos_gerados), 1);

    // 6/3 loaded mid-ALTO: current period stays 10/4
    roda(1);
    carrega(6, 3, 1);
    empilha(6, 3);
    empilha(6, 3);
    roda(exp_q.size());
    verifica("ciclos_3", int'(bus.ciclos_gerados), 3);

    // rejected loads leave waveform untouched
    empilha(6, 3);
    carrega(1, 1, 1);
    verifica("erro_p1", int'(bus.erro_config), 1);
    carrega(10, 0, 1);
    verifica("erro_l0", int'(bus.erro_config), 1);
    carrega(5, 5, 1);
    verifica("erro_leqp", int'(bus.erro_config), 1);
    carrega(8, 2, 1);
    verifica("erro_limpo", int'(bus.erro_config), 0);
    empilha(8, 2);
    empilha(8, 2);
    roda(exp_q.size());
    verifica("ciclos_6", int'(bus.ciclos_gerados), 6);

    // load on the boundary edge waits one more period
    empilha(8, 2);
    carrega(10, 4, 1);
    empilha(10, 4);
    roda(14);
    verifica("ciclos_8", int'(bus.ciclos_gerados), 8);

    // habilita dropped at cycle 7
    bus.habilita = 1'b0;
    tick();
    exp_q.delete();
    verifica("parar_sinal", int'(bus.sinal), 0);
    verifica("parar_ocup", int'(bus.ocupado), 0);
    verifica("parar_ciclos", int'(bus.ciclos_gerados), 8);
    repeat (3) tick();
    verifica("parado_ciclos", int'(bus.ciclos_gerados), 8);

    // restart, then async reset mid-period
    bus.habilita = 1'b1;
    empilha(10, 4);
    roda(5);
    #2;
    reset = 1'b1;
    #1;
    verifica("arst_sinal", int'(bus.sinal), 0);
    verifica("arst_ocup", int'(bus.ocupado), 0);
    verifica("arst_ciclos", int'(bus.ciclos_gerados), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) tick();
    verifica("pos_rst_hab", int'(bus.ocupado), 0);
    bus.habilita = 1'b0;

    // 2/1 up to wrap of ciclos_gerados
    carrega(2, 1, 0);
    bus.habilita = 1'b1;
    for (int i = 0; i < 4095; i++) begin
      empilha(2, 1);
      roda(2);
    end
    verifica("ciclos_4094", int'(bus.ciclos_gerados), 4094);
    empilha(2, 1);
    roda(1);
    verifica("ciclos_4095", int'(bus.ciclos_gerados), 4095);
    roda(1);
    empilha(2, 1);
    roda(1);
    verifica("ciclos_wrap", int'(bus.ciclos_gerados), 0);
    verifica("erro_final", int'(bus.erro_config), 0);

    // closed loop: measure period of 20/5 from rising edges
    carrega(20, 5, 1);
    subidas = 0;
    ultimo  = 0;
    gap     = 0;
    ant     = bus.sinal;
    for (int c = 0; c < 200 && subidas < 3; c++) begin
      tick();
      if (bus.sinal && !ant) begin
        subidas++;
        if (subidas >= 2) gap = c - ultimo;
        ultimo = c;
      end
      ant = bus.sinal;
    end
    verifica("medida_subidas", subidas, 3);
    verifica("periodo_medido", gap, 20);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
